// File: rtl/sd_decimator.sv
// -----------------------------------------------------------------------------
// sd_decimator
//
// Purpose:
//   Converts a unipolar 1-bit sigma-delta stream into unsigned PCM samples
//   with an ORDER-stage CIC decimator. The decimation ratio is R = 2**RATE_LOG2.
//   The integrators run at the `en` rate. The combs run once per decimated
//   token, and a token moves one stage per clk. The result is presented on a
//   valid/ready port with overrun detection.
//
// Parameters:
//   ORDER      number of integrator / comb stages (1..4)
//   RATE_LOG2  log2 of the decimation ratio (>= 3)
//   W          datapath / output width, fixed at ORDER*RATE_LOG2+1
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         sigma-delta sample enable; `in` is used only when en is high
//   in         sigma-delta bit (1 -> +1, 0 -> 0)
//   out_data   decimated sample, 0..R**ORDER
//   out_valid  out_data holds an unconsumed sample
//   out_ready  consumer accepts out_data when out_valid is also high
//   overrun    one-cycle pulse when an unconsumed sample is overwritten
// -----------------------------------------------------------------------------
module sd_decimator #(
  parameter  int ORDER     = 3,
  parameter  int RATE_LOG2 = 5,
  localparam int W         = ORDER * RATE_LOG2 + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun
);

  // The prime counter stops here. Tokens that exit before it gets here are
  // start-up transients and are not loaded into the output register.
  localparam logic [2:0] PRIME_LAST = 3'(ORDER + 1);

  // ---------------------------------------------------------------------------
  // Integrator cascade
  // ---------------------------------------------------------------------------
  logic [W-1:0]         r_integ    [ORDER];
  logic [W-1:0]         w_integ_in [ORDER];
  logic [RATE_LOG2-1:0] r_phase;
  logic                 w_tick;

  // Stage 0 accumulates the input bit. Every later stage accumulates the
  // registered (pre-update) value of the stage before it.
  for (genvar gi = 0; gi < ORDER; gi++) begin : g_integ_in
    if (gi == 0) begin : g_first
      assign w_integ_in[gi] = {{(W-1){1'b0}}, in};
    end else begin : g_rest
      assign w_integ_in[gi] = r_integ[gi-1];
    end
  end

  // Modulo-2^W wrap is intended. The comb differences cancel it exactly
  // because the true output never exceeds R**ORDER < 2**W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= r_integ[k] + w_integ_in[k];
      end
    end
  end

  // The phase counter wraps R-1 -> 0 naturally at RATE_LOG2 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
    end else if (en) begin
      r_phase <= r_phase + 1'b1;
    end
  end

  assign w_tick = en & (&r_phase);

  // ---------------------------------------------------------------------------
  // Comb input register: captures the last integrator before it updates.
  // ---------------------------------------------------------------------------
  logic [W-1:0] r_comb_in;
  logic         r_comb_in_tok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_comb_in     <= '0;
      r_comb_in_tok <= 1'b0;
    end else begin
      r_comb_in_tok <= w_tick;
      if (w_tick) begin
        r_comb_in <= r_integ[ORDER-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comb pipeline: one token advances one stage per clk, regardless of en.
  // ---------------------------------------------------------------------------
  logic [W-1:0]     r_comb_dat  [ORDER];
  logic [W-1:0]     r_comb_prev [ORDER];
  logic [ORDER-1:0] r_comb_tok;
  logic [W-1:0]     w_comb_x    [ORDER];
  logic [ORDER-1:0] w_comb_v;

  for (genvar gi = 0; gi < ORDER; gi++) begin : g_comb_in
    if (gi == 0) begin : g_first
      assign w_comb_x[gi] = r_comb_in;
      assign w_comb_v[gi] = r_comb_in_tok;
    end else begin : g_rest
      assign w_comb_x[gi] = r_comb_dat[gi-1];
      assign w_comb_v[gi] = r_comb_tok[gi-1];
    end
  end

  // x_prev moves only with a token, so each comb differences consecutive
  // decimated samples. Idle cycles in between do not disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_comb_tok <= '0;
      for (int k = 0; k < ORDER; k++) begin
        r_comb_dat[k]  <= '0;
        r_comb_prev[k] <= '0;
      end
    end else begin
      r_comb_tok <= w_comb_v;
      for (int k = 0; k < ORDER; k++) begin
        if (w_comb_v[k]) begin
          r_comb_dat[k]  <= w_comb_x[k] - r_comb_prev[k];
          r_comb_prev[k] <= w_comb_x[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priming and output register
  // ---------------------------------------------------------------------------
  logic [2:0]   r_prime;
  logic         w_exit;
  logic         w_primed;
  logic         w_load;
  logic [W-1:0] r_out_data;
  logic         r_out_valid;
  logic         r_overrun;

  assign w_exit   = r_comb_tok[ORDER-1];
  assign w_primed = (r_prime == PRIME_LAST);
  assign w_load   = w_exit & w_primed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prime <= '0;
    end else if (w_exit && !w_primed) begin
      r_prime <= r_prime + 3'd1;
    end
  end

  // A load takes precedence over a handshake in the same cycle. The new
  // sample stays valid, and the consumed one does not count as overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_load & r_out_valid & ~out_ready;
      if (w_load) begin
        r_out_data  <= r_comb_dat[ORDER-1];
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sd_decimator.sv
// -----------------------------------------------------------------------------
// tb_sd_decimator
//
// Directed bench for sd_decimator at the default parameters (ORDER=3, R=32).
//
// Hand-derived reference values:
//   - Steady state for all ones: R**3 = 32768.
//   - Steady state for alternating 1010: 16 * 32 * 32 = 16384.
//   - Zeros up to tick T, then ones: the captured integrator values are
//     C(kR-1,3) for k >= 1 after the switch. The third difference gives the
//     sample sequence 4495, 26226, 32767, 32768.
// -----------------------------------------------------------------------------
module tb_sd_decimator;

  localparam int ORDER     = 3;
  localparam int RATE_LOG2 = 5;
  localparam int W         = 16;
  localparam int R         = 32;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         en        = 1'b0;
  logic         in_bit    = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         overrun;

  sd_decimator #(
    .ORDER    (ORDER),
    .RATE_LOG2(RATE_LOG2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in_bit),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc;
  int   en_cnt;
  int   en_div;
  int   div_cnt;
  int   pat;            // 0 zeros, 1 ones, 2 alternating starting with 1
  logic alt_bit;
  int   ovr_cnt;
  int   first_valid_cyc;
  int   n_before;
  int   tick_cyc  [$];
  int   samp_data [$];
  int   samp_cyc  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One loop pass drives the inputs and records a handshake if one is about
  // to happen at the coming edge. It then clocks once and samples 1 ns later.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      en     = (en_div != 0) && (div_cnt == 0);
      in_bit = (pat == 1) ? 1'b1 : ((pat == 2) ? alt_bit : 1'b0);
      if (out_valid && out_ready) begin
        samp_data.push_back(int'(out_data));
        samp_cyc.push_back(cyc);
        $display("sample %0d cyc=%0d data=%0d", samp_data.size(), cyc, out_data);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (en) begin
        en_cnt++;
        if (pat == 2) alt_bit = ~alt_bit;
        if (en_cnt % R == 0) tick_cyc.push_back(cyc);
      end
      if (en_div != 0) div_cnt = (div_cnt + 1) % en_div;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (overrun) ovr_cnt++;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    en     = 1'b0;
    in_bit = 1'b0;
    @(posedge clk);
    #1;
    rst             = 1'b1;
    cyc             = 0;
    en_cnt          = 0;
    div_cnt         = 0;
    alt_bit         = 1'b1;
    ovr_cnt         = 0;
    first_valid_cyc = -1;
    tick_cyc.delete();
    samp_data.delete();
    samp_cyc.delete();
  endtask

  initial begin
    en_div = 1;
    pat    = 0;

    // Reset state, with async reset asserted before any clock edge
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overrun", overrun, 0);

    // 1) Constant ones, en continuous, ready high
    do_reset();
    pat = 1; en_div = 1; out_ready = 1'b1;
    run(163);
    chk("ones_no_early_valid", first_valid_cyc, -1);
    run(1);
    chk("ones_latency", first_valid_cyc - tick_cyc[4], ORDER + 1);
    run(3 * R + 6);
    chk("ones_count", samp_data.size(), 4);
    for (int i = 0; i < samp_data.size(); i++) chk("ones_value", samp_data[i], 32768);
    for (int i = 1; i < samp_cyc.size(); i++) chk("ones_spacing", samp_cyc[i] - samp_cyc[i-1], R);
    chk("ones_no_overrun", ovr_cnt, 0);

    // 2) Constant zeros
    do_reset();
    pat = 0; en_div = 1; out_ready = 1'b1;
    run(7 * R + 6);
    chk("zeros_ticks", tick_cyc.size(), 7);
    chk("zeros_count", samp_data.size(), 3);
    chk("zeros_latency", first_valid_cyc - tick_cyc[4], ORDER + 1);
    for (int i = 0; i < samp_data.size(); i++) chk("zeros_value", samp_data[i], 0);
    for (int i = 1; i < samp_cyc.size(); i++) chk("zeros_spacing", samp_cyc[i] - samp_cyc[i-1], R);

    // 3) Alternating, then all ones from a tick boundary
    do_reset();
    pat = 2; en_div = 1; out_ready = 1'b1;
    run(7 * R);
    pat = 1;
    run(6 * R + 6);
    chk("alt_count", samp_data.size(), 9);
    for (int i = 0; i < 3; i++) chk("alt_value", samp_data[i], 16384);
    for (int i = 3; i < samp_data.size(); i++) chk("alt_monotonic", samp_data[i] >= samp_data[i-1], 1);
    for (int i = 6; i < samp_data.size(); i++) chk("alt_settled", samp_data[i], 32768);

    // 4) en 1-in-3 with all ones, then a 200-cycle en gap
    do_reset();
    pat = 1; en_div = 3; out_ready = 1'b1;
    run(8 * 3 * R + 10);
    chk("slow_count", samp_data.size(), 4);
    for (int i = 0; i < samp_data.size(); i++) chk("slow_value", samp_data[i], 32768);
    for (int i = 1; i < samp_cyc.size(); i++) chk("slow_spacing", samp_cyc[i] - samp_cyc[i-1], 3 * R);
    n_before = samp_data.size();
    en_div = 0;
    run(200);
    chk("gap_no_sample", samp_data.size(), n_before);
    en_div = 3; div_cnt = 0;
    run(2 * 3 * R + 10);
    chk("resume_count", samp_data.size(), 6);
    chk("resume_value_a", samp_data[4], 32768);
    chk("resume_value_b", samp_data[5], 32768);

    // 5) Overrun: zeros to tick 5, then ones, consumer stalled across two ticks
    do_reset();
    pat = 0; en_div = 1; out_ready = 1'b1;
    run(5 * R);
    pat = 1;
    run(10);
    out_ready = 1'b0;
    run(64);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_valid_held", out_valid, 1);
    chk("ovr_newer_data", out_data, 26226);
    chk("ovr_first_sample", samp_data[0], 0);
    out_ready = 1'b1;
    run(1);
    chk("ovr_valid_cleared", out_valid, 0);
    run(70);
    chk("ovr_count", samp_data.size(), 4);
    chk("ovr_consumed", samp_data[1], 26226);
    chk("settle_3", samp_data[2], 32767);
    chk("settle_4", samp_data[3], 32768);
    chk("ovr_no_more", ovr_cnt, 1);

    // 6) Reset two cycles after a tick, with a valid sample held
    do_reset();
    pat = 1; en_div = 1; out_ready = 1'b0;
    run(170);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, 32768);
    run(6 * R + 2 - 170);
    rst = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_overrun", overrun, 0);
    do_reset();
    pat = 1; en_div = 1; out_ready = 1'b1;
    run(4 * R + 6);
    chk("reprime_no_valid", first_valid_cyc, -1);
    chk("reprime_no_overrun", ovr_cnt, 0);
    run(R + 4);
    chk("reprime_count", samp_data.size(), 1);
    chk("reprime_value", samp_data[0], 32768);
    chk("reprime_latency", first_valid_cyc - tick_cyc[4], ORDER + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
